xyj_monitor: RTL
================

Name: xyj_monitor

Overview:
- Plant-side receiver for the washer controller's actuator bus (JS, PS, ZZ, FZ, QX, PX, TS, BJ).
- Samples the command lines every cp cycle and models drum water level.
- Enforces interlocks, raising sticky fault flags on illegal combinations.
- Counts fills and motor reversals, and reports a decoded phase code for the panel/display logic.

Parameters:
- LVL_W, 4, width of the water-level model register.
- LVL_MAX, 4'd2, full level; level saturates here.
- DEAD_MIN, 1, minimum idle cycles (ZZ=0 and FZ=0) required between opposite motor directions.
- CNT_W, 8, width of fill_cnt and rev_cnt.

Ports:
- cp  in  1  clock; all state changes on rising edge.
- R  in  1  reset, asynchronous, active-low.
- EN  in  1  monitor enable. When low, hold all state and ignore the bus.
- JS, PS, ZZ, FZ, QX, PX, TS, BJ  in  1 each  controller command lines.
- level  out  LVL_W  modelled water level.
- phase  out  3  decoded phase: 0 IDLE, 1 FILL, 2 AGITATE, 3 PAUSE, 4 DRAIN, 5 SPIN, 6 ALARM.
- fault  out  6  sticky flags: [0] DIR, [1] DEAD, [2] FILLDRAIN, [3] MODE, [4] DRY, [5] FLOOD.
- fault_any  out  1  OR of fault, registered.
- fill_cnt  out  CNT_W  count of JS rising edges.
- rev_cnt  out  CNT_W  count of motor direction reversals.
- done  out  1  one-cycle pulse on BJ rising edge.

Behaviour:
- Reset (R=0, async): all outputs 0, prev-input registers 0, motor FSM in M_NONE, idle_cnt 0.
- All outputs are registered. Inputs sampled at edge k appear on outputs after edge k (1-cycle latency). No combinational paths from inputs to outputs.
- EN=0: nothing updates, including the edge-detect registers. A JS held high across an EN gap does not count as a new fill.
- Level model, each enabled cycle:
  - JS&!PS: level+1, saturating at LVL_MAX.
  - PS&!JS: level-1, saturating at 0.
  - Both or neither: hold.
- Fault conditions, evaluated on sampled inputs (old level). Each flag sets and stays set until reset:
  - DIR: ZZ&FZ.
  - FILLDRAIN: JS&PS.
  - MODE: QX&PX.
  - DRY: (ZZ|FZ)&!TS&level==0. Spin (TS=1) is exempt.
  - FLOOD: JS&level==LVL_MAX&!PS.
- Motor FSM:
  - States: M_NONE (no direction seen since reset), M_FWD, M_REV, M_GAP_F (idle after FWD), M_GAP_R (idle after REV). idle_cnt counts cycles spent in a GAP state.
  - M_NONE: ZZ->M_FWD, FZ->M_REV.
  - M_FWD: ZZ stays; neither -> M_GAP_F with idle_cnt=1; FZ -> M_REV, rev_cnt+1, DEAD set (zero gap).
  - M_GAP_F: neither -> idle_cnt+1, saturating at DEAD_MIN; ZZ -> M_FWD, no reversal; FZ -> M_REV, rev_cnt+1, DEAD set if idle_cnt<DEAD_MIN.
  - M_REV and M_GAP_R: symmetric.
  - ZZ&FZ together: DIR set, FSM state held.
  - When TS=1, ZZ-only is treated as spin: no reversal bookkeeping, FSM held.
- phase priority: BJ -> 6; TS -> 5; PS -> 4; JS -> 3'd1; ZZ|FZ -> 2; QX|PX -> 3; else 0.
- fill_cnt and rev_cnt wrap modulo 2^CNT_W.
- done = BJ & !BJ_prev.
- Reset asserted mid-operation clears everything immediately, regardless of cp.

Decomposition:
- Shared package xyj_pkg holds:
  - phase codes PH_IDLE..PH_ALARM;
  - fault bit indices F_DIR..F_FLOOD;
  - motor state encoding.
- The controller also imports xyj_pkg for the phase codes.
- One sub-module, xyj_motor_chk, contains the motor FSM, idle_cnt, rev_cnt and the DEAD/DIR detection. The top level holds the level model, the other faults, phase decoding and the counters.

Test Plan:
- Reset then a legal program: JS 2 cycles, ZZ 3, idle 1, FZ 3, idle 1, PS 2. Required: level 0->1->2->...->0; rev_cnt=1; fill_cnt=1; fault=0; phase sequence 1,1,2,2,2,3,2,2,2,3,4,4.
- ZZ 3 cycles then FZ immediately with DEAD_MIN=1 -> fault[1]=1 after the first FZ edge; rev_cnt=1; fault_any=1 one cycle later; flag stays set through 10 further legal cycles.
- ZZ with level=0 and TS=0 -> fault[4]=1. Same stimulus with TS=1 -> fault[4]=0 and phase=5.
- JS held 4 cycles with LVL_MAX=2 -> level saturates at 2; fault[5] sets on the 3rd JS cycle. JS&PS together for one cycle -> fault[2]=1, level unchanged.
- JS=1, then EN=0 for 3 cycles, then EN=1 with JS still 1 -> fill_cnt stays 1 and level frozen during the gap. BJ rising -> done=1 for exactly one cycle, phase=6.
- Assert R low mid-FWD, asynchronously between cp edges -> all outputs 0 before the next edge; after release, the first FZ is not a reversal (M_NONE).

Source files
------------

// File: rtl/xyj_pkg.sv
// Shared encodings for the washer actuator-bus monitor.
// Phase codes, fault bit positions and motor direction states.
package xyj_pkg;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_FILL    = 3'd1,
    PH_AGITATE = 3'd2,
    PH_PAUSE   = 3'd3,
    PH_DRAIN   = 3'd4,
    PH_SPIN    = 3'd5,
    PH_ALARM   = 3'd6
  } phase_e;

  localparam int F_DIR       = 0;
  localparam int F_DEAD      = 1;
  localparam int F_FILLDRAIN = 2;
  localparam int F_MODE      = 3;
  localparam int F_DRY       = 4;
  localparam int F_FLOOD     = 5;
  localparam int NFAULT      = 6;

  typedef enum logic [2:0] {
    M_NONE  = 3'd0,
    M_FWD   = 3'd1,
    M_REV   = 3'd2,
    M_GAP_F = 3'd3,
    M_GAP_R = 3'd4
  } mstate_e;

endpackage

// File: rtl/xyj_motor_chk.sv
// Motor direction tracker: counts reversals, flags missing
// dead time between opposite directions and both-on commands.
module xyj_motor_chk
  import xyj_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int DEAD_MIN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             zz,
  input  logic             fz,
  input  logic             ts,
  output logic [CNT_W-1:0] rev_cnt,
  output logic             dead,
  output logic             dir
);

  localparam int IDLE_W = $clog2(DEAD_MIN + 2);
  localparam logic [IDLE_W-1:0] DMIN = IDLE_W'(DEAD_MIN);
  localparam logic [IDLE_W-1:0] ONE  = IDLE_W'(1);
  localparam logic [CNT_W-1:0]  CONE = CNT_W'(1);

  mstate_e           state;
  logic [IDLE_W-1:0] idle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= M_NONE;
      idle_cnt <= '0;
      rev_cnt  <= '0;
      dead     <= 1'b0;
      dir      <= 1'b0;
    end else if (en) begin
      if (zz && fz) begin
        dir <= 1'b1;
      // forward drive during spin is not agitation
      end else if (!(ts && zz)) begin
        case (state)
          M_NONE: begin
            if (zz)      state <= M_FWD;
            else if (fz) state <= M_REV;
          end
          M_FWD: begin
            if (fz) begin
              state   <= M_REV;
              rev_cnt <= rev_cnt + CONE;
              dead    <= 1'b1;
            end else if (!zz) begin
              state    <= M_GAP_F;
              idle_cnt <= ONE;
            end
          end
          M_REV: begin
            if (zz) begin
              state   <= M_FWD;
              rev_cnt <= rev_cnt + CONE;
              dead    <= 1'b1;
            end else if (!fz) begin
              state    <= M_GAP_R;
              idle_cnt <= ONE;
            end
          end
          M_GAP_F: begin
            if (fz) begin
              state    <= M_REV;
              rev_cnt  <= rev_cnt + CONE;
              idle_cnt <= '0;
              if (idle_cnt < DMIN) dead <= 1'b1;
            end else if (zz) begin
              state    <= M_FWD;
              idle_cnt <= '0;
            end else if (idle_cnt < DMIN) begin
              idle_cnt <= idle_cnt + ONE;
            end
          end
          M_GAP_R: begin
            if (zz) begin
              state    <= M_FWD;
              rev_cnt  <= rev_cnt + CONE;
              idle_cnt <= '0;
              if (idle_cnt < DMIN) dead <= 1'b1;
            end else if (fz) begin
              state    <= M_REV;
              idle_cnt <= '0;
            end else if (idle_cnt < DMIN) begin
              idle_cnt <= idle_cnt + ONE;
            end
          end
          default: state <= M_NONE;
        endcase
      end
    end
  end

endmodule

// File: rtl/xyj_monitor.sv
// Plant-side actuator-bus monitor: water level model, sticky
// interlock faults, fill/reversal counters and phase decode.
module xyj_monitor
  import xyj_pkg::*;
#(
  parameter int               LVL_W    = 4,
  parameter logic [LVL_W-1:0] LVL_MAX  = LVL_W'(2),
  parameter int               DEAD_MIN = 1,
  parameter int               CNT_W    = 8
) (
  input  logic              cp,
  input  logic              R,
  input  logic              EN,
  input  logic              JS,
  input  logic              PS,
  input  logic              ZZ,
  input  logic              FZ,
  input  logic              QX,
  input  logic              PX,
  input  logic              TS,
  input  logic              BJ,
  output logic [LVL_W-1:0]  level,
  output logic [2:0]        phase,
  output logic [NFAULT-1:0] fault,
  output logic              fault_any,
  output logic [CNT_W-1:0]  fill_cnt,
  output logic [CNT_W-1:0]  rev_cnt,
  output logic              done
);

  localparam logic [LVL_W-1:0] LONE = LVL_W'(1);
  localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

  logic             js_q;
  logic             bj_q;
  logic             f_fd;
  logic             f_mode;
  logic             f_dry;
  logic             f_flood;
  logic             m_dead;
  logic             m_dir;
  logic [LVL_W-1:0] lvl_nx;
  phase_e           ph_nx;

  xyj_motor_chk #(
    .CNT_W    (CNT_W),
    .DEAD_MIN (DEAD_MIN)
  ) u_motor (
    .clk     (cp),
    .rst_n   (R),
    .en      (EN),
    .zz      (ZZ),
    .fz      (FZ),
    .ts      (TS),
    .rev_cnt (rev_cnt),
    .dead    (m_dead),
    .dir     (m_dir)
  );

  always_comb begin
    fault              = '0;
    fault[F_DIR]       = m_dir;
    fault[F_DEAD]      = m_dead;
    fault[F_FILLDRAIN] = f_fd;
    fault[F_MODE]      = f_mode;
    fault[F_DRY]       = f_dry;
    fault[F_FLOOD]     = f_flood;
  end

  always_comb begin
    lvl_nx = level;
    if (JS && !PS && level < LVL_MAX)
      lvl_nx = level + LONE;
    else if (PS && !JS && level != '0)
      lvl_nx = level - LONE;
  end

  always_comb begin
    if (BJ)            ph_nx = PH_ALARM;
    else if (TS)       ph_nx = PH_SPIN;
    else if (PS)       ph_nx = PH_DRAIN;
    else if (JS)       ph_nx = PH_FILL;
    else if (ZZ || FZ) ph_nx = PH_AGITATE;
    else if (QX || PX) ph_nx = PH_PAUSE;
    else               ph_nx = PH_IDLE;
  end

  always_ff @(posedge cp or negedge R) begin
    if (!R) begin
      level     <= '0;
      phase     <= PH_IDLE;
      fault_any <= 1'b0;
      fill_cnt  <= '0;
      done      <= 1'b0;
      js_q      <= 1'b0;
      bj_q      <= 1'b0;
      f_fd      <= 1'b0;
      f_mode    <= 1'b0;
      f_dry     <= 1'b0;
      f_flood   <= 1'b0;
    end else if (EN) begin
      level     <= lvl_nx;
      phase     <= ph_nx;
      fault_any <= |fault;
      done      <= BJ && !bj_q;
      js_q      <= JS;
      bj_q      <= BJ;
      if (JS && !js_q)
        fill_cnt <= fill_cnt + CONE;
      if (JS && PS)
        f_fd <= 1'b1;
      if (QX && PX)
        f_mode <= 1'b1;
      // fault checks use the level before this cycle's update
      if ((ZZ || FZ) && !TS && level == '0)
        f_dry <= 1'b1;
      if (JS && !PS && level == LVL_MAX)
        f_flood <= 1'b1;
    end
  end

endmodule
